// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer and its ALU: op encoding, widths, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_sequencer_pkg;

    localparam int DW   = 8;
    localparam int NREG = 4;
    localparam int RW   = $clog2(NREG);

    typedef enum logic [1:0] {
        OP_SUB  = 2'd0,
        OP_ADD  = 2'd1,
        OP_NAND = 2'd2,
        OP_RSVD = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    // Per-command bookkeeping that must survive until the EXEC cycle.
    typedef struct packed {
        logic [RW-1:0] rd;
        logic          nowb;
    } cmd_meta_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: SUB (b - a, carry = no-borrow), ADD, NAND; op 3 yields 0.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows inputs.
module alu
    import alu_sequencer_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [1:0]    op,
    output logic [DW-1:0] result,
    output logic          zero,
    output logic          carry
);

    logic [DW:0] sum;

    // Result and carry per operation; the reserved op returns all-zero with no flags.
    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (alu_op_e'(op))
            OP_SUB: begin
                sum    = {1'b0, b} - {1'b0, a};
                result = sum[DW-1:0];
                carry  = ~sum[DW];
            end
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DW-1:0];
                carry  = sum[DW];
            end
            OP_NAND: result = ~(a & b);
            default: ;
        endcase
    end

    assign zero = (op != OP_RSVD) && (result == '0);

endmodule

// File: rtl/regfile.sv
// Four-entry register file: two asynchronous read ports, one synchronous write port.
// Latency: reads combinational; a write is visible after the clock edge that performs it.
// Backpressure: none; a write is taken whenever we is high.
module regfile
    import alu_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] raddr0,
    output logic [DW-1:0] rdata0,
    input  logic [RW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [NREG-1:0][DW-1:0] mem;

    // Synchronous clear, then single-port write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/alu_sequencer.sv
// Issues one register/immediate command at a time to an external ALU and writes back the result.
// Latency: accept at edge N, register/flags/response written at edge N+1; one command per 3 cycles max.
// Backpressure: cmd_ready only in IDLE; response held stable in RESP until rsp_ready.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [RW-1:0] cmd_rd,
    input  logic [RW-1:0] cmd_rs,
    input  logic          cmd_use_imm,
    input  logic [DW-1:0] cmd_imm,
    input  logic          cmd_nowb,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [1:0]    alu_op,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_zero,
    input  logic          alu_carry,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_zero,
    output logic          rsp_carry
);

    seq_state_e    state_q, state_d;
    cmd_meta_t     meta_q;
    logic          accept;
    logic          rf_we;
    logic [DW-1:0] rf_rs_dat;
    logic [DW-1:0] rf_rd_dat;
    // The {Z,C} flag register and the response flags are captured at the same
    // moment and cleared by the same reset, so one register serves both.
    logic [1:0]    flags_q;

    regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr0 (cmd_rs),
        .rdata0 (rf_rs_dat),
        .raddr1 (cmd_rd),
        .rdata1 (rf_rd_dat),
        .we     (rf_we),
        .waddr  (meta_q.rd),
        .wdata  (alu_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; cmd_ready is held low while reset is asserted.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        rf_we     = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rf_we   = ~meta_q.nowb;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch: the ALU inputs are the latched operands themselves, so they
    // change only on acceptance and hold the last-issued values otherwise.
    // Both operands are read before any write, so rd == rs sees the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            meta_q <= '0;
        end else if (accept) begin
            alu_a  <= cmd_use_imm ? cmd_imm : rf_rs_dat;
            alu_b  <= rf_rd_dat;
            alu_op <= cmd_op;
            meta_q <= '{rd: cmd_rd, nowb: cmd_nowb};
        end
    end

    // Capture result and flags at the end of the EXEC cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data <= '0;
            flags_q  <= '0;
        end else if (state_q == ST_EXEC) begin
            rsp_data <= alu_out;
            flags_q  <= {alu_zero, alu_carry};
        end
    end

    assign rsp_zero  = flags_q[1];
    assign rsp_carry = flags_q[0];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with the ALU attached: vector table plus multi-cycle corner sequences.
// Latency: checks the accept / EXEC / RESP cycle timing of every command.
// Backpressure: exercises rsp_ready stalls and commands offered while busy.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op, cmd_rd, cmd_rs;
    logic       cmd_use_imm, cmd_nowb;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [1:0] alu_op;
    logic       alu_zero, alu_carry;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero, rsp_carry;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       use_imm;
        logic [7:0] imm;
        logic       nowb;
        logic [7:0] exp_data;
        logic       exp_z;
        logic       exp_c;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_use_imm(cmd_use_imm),
        .cmd_imm(cmd_imm), .cmd_nowb(cmd_nowb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry)
    );

    alu u_alu (
        .a(alu_a), .b(alu_b), .op(alu_op),
        .result(alu_out), .zero(alu_zero), .carry(alu_carry)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                                input logic use_imm, input logic [7:0] imm, input logic nowb,
                                input logic [7:0] d, input logic z, input logic c);
        vec_t v;
        v.op = op; v.rd = rd; v.rs = rs; v.use_imm = use_imm; v.imm = imm;
        v.nowb = nowb; v.exp_data = d; v.exp_z = z; v.exp_c = c;
        return v;
    endfunction

    // Read a register without changing it: ADD imm 0, no writeback.
    function automatic vec_t probe(input logic [1:0] r, input logic [7:0] val);
        return mk(OP_ADD, r, 2'd0, 1'b1, 8'h00, 1'b1, val, val == 8'h00, 1'b0);
    endfunction

    task automatic drive_cmd(input vec_t v);
        cmd_op = v.op; cmd_rd = v.rd; cmd_rs = v.rs;
        cmd_use_imm = v.use_imm; cmd_imm = v.imm; cmd_nowb = v.nowb;
    endtask

    // One full command: accept, EXEC, RESP, release, back to IDLE.
    task automatic run_cmd(input vec_t v, input string name);
        @(negedge clk);
        drive_cmd(v);
        cmd_valid = 1'b1;
        chk({name, " ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({name, " exec_no_rsp"}, 32'(rsp_valid), 32'd0);
        chk({name, " exec_op"}, 32'(alu_op), 32'(v.op));
        if (v.use_imm) chk({name, " exec_a"}, 32'(alu_a), 32'(v.imm));
        @(posedge clk); #1;
        chk({name, " rsp"}, 32'({rsp_valid, rsp_data, rsp_zero, rsp_carry}),
            32'({1'b1, v.exp_data, v.exp_z, v.exp_c}));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({name, " idle"}, 32'({cmd_ready, rsp_valid}), 32'b10);
        chk({name, " op_hold"}, 32'(alu_op), 32'(v.op));
        if (!cmd_ready) begin
            rsp_ready = 1'b1;
            for (int k = 0; k < 8 && !cmd_ready; k++) begin
                @(posedge clk); #1;
            end
            rsp_ready = 1'b0;
            if (!cmd_ready) begin
                $display("FAIL %s recover: got cmd_ready 0 expected 1", name);
                $fatal(1, "sequencer stuck");
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_use_imm = 1'b0; cmd_imm = '0; cmd_nowb = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst rsp", 32'({rsp_valid, rsp_data, rsp_zero, rsp_carry}), 32'd0);
        chk("rst alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst release ready", 32'(cmd_ready), 32'd1);

        vecs.push_back(mk(OP_ADD,  2'd1, 2'd0, 1'b1, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0));
        vecs.push_back(probe(2'd1, 8'h05));
        vecs.push_back(mk(OP_NAND, 2'd1, 2'd0, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(OP_ADD,  2'd1, 2'd0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1));
        vecs.push_back(probe(2'd1, 8'h00));
        vecs.push_back(mk(OP_NAND, 2'd2, 2'd0, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(OP_NAND, 2'd2, 2'd0, 1'b1, 8'hFC, 1'b0, 8'h03, 1'b0, 1'b0));
        vecs.push_back(mk(OP_NAND, 2'd3, 2'd0, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(OP_NAND, 2'd3, 2'd0, 1'b1, 8'hFA, 1'b0, 8'h05, 1'b0, 1'b0));
        vecs.push_back(mk(OP_SUB,  2'd2, 2'd3, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0));
        vecs.push_back(mk(OP_NAND, 2'd2, 2'd0, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(OP_NAND, 2'd2, 2'd0, 1'b1, 8'hFC, 1'b0, 8'h03, 1'b0, 1'b0));
        vecs.push_back(mk(OP_SUB,  2'd3, 2'd2, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1));
        vecs.push_back(mk(OP_NAND, 2'd0, 2'd0, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(OP_NAND, 2'd0, 2'd0, 1'b1, 8'hF0, 1'b1, 8'h0F, 1'b0, 1'b0));
        vecs.push_back(probe(2'd0, 8'hFF));
        vecs.push_back(mk(OP_ADD,  2'd3, 2'd3, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0, 1'b0));
        vecs.push_back(probe(2'd3, 8'h04));
        vecs.push_back(mk(OP_SUB,  2'd0, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(OP_RSVD, 2'd3, 2'd0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(probe(2'd3, 8'h00));
        vecs.push_back(mk(OP_SUB,  2'd3, 2'd0, 1'b1, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(OP_ADD,  2'd3, 2'd0, 1'b1, 8'h80, 1'b0, 8'h7F, 1'b0, 1'b1));
        vecs.push_back(probe(2'd3, 8'h7F));

        foreach (vecs[i]) run_cmd(vecs[i], $sformatf("v%0d", i));

        // Response backpressure with a second command offered while busy.
        @(negedge clk);
        drive_cmd(mk(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0));
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        drive_cmd(mk(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0));
        @(posedge clk); #1;
        chk("bp first rsp", 32'({rsp_valid, rsp_data, rsp_zero, rsp_carry}), 32'({1'b1, 8'h11, 2'b00}));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d rsp", c), 32'({rsp_valid, rsp_data, rsp_zero, rsp_carry}),
                32'({1'b1, 8'h11, 2'b00}));
            chk($sformatf("bp hold%0d ready", c), 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp release idle", 32'({cmd_ready, rsp_valid}), 32'b10);
        run_cmd(probe(2'd1, 8'h11), "bp probe r1");

        // Reset asserted during EXEC aborts the command.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_cmd(mk(OP_ADD, 2'd2, 2'd0, 1'b1, 8'h09, 1'b0, 8'h00, 1'b0, 1'b0));
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        chk("exec rst ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("exec rst rsp", 32'({rsp_valid, rsp_data, rsp_zero, rsp_carry}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("exec rst release", 32'({cmd_ready, rsp_valid}), 32'b10);
        run_cmd(probe(2'd2, 8'h00), "exec rst probe r2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
